// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth MAC: FSM states, digit codes and iteration count.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CAL  = 2'b01,
        DONE = 2'b10
    } booth_state_e;

    // Encoded as {neg, one, two}.
    typedef enum logic [2:0] {
        ZERO = 3'b000,
        POS1 = 3'b010,
        POS2 = 3'b001,
        NEG1 = 3'b110,
        NEG2 = 3'b101
    } booth_digit_e;

    function automatic int booth_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_mac_if.sv
// Operand/result handshake bundle for booth_r4_mac.
interface booth_r4_mac_if #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  in_signed;
    logic                  in_acc;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  dout;
    logic                  busy;

    modport slave (
        input  in_valid, din0, din1, in_signed, in_acc, out_ready,
        output in_ready, out_valid, dout, busy
    );

    modport master (
        output in_valid, din0, din1, in_signed, in_acc, out_ready,
        input  in_ready, out_valid, dout, busy
    );
endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps one overlapping multiplier bit triplet to a digit code.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] i_triplet,
    output logic       o_neg,
    output logic       o_one,
    output logic       o_two
);
    booth_digit_e w_digit;

    // Triplet {y[2i+1], y[2i], y[2i-1]} to digit in {0, +-M, +-2M}.
    always_comb begin
        w_digit = ZERO;
        case (i_triplet)
            3'b001, 3'b010: w_digit = POS1;
            3'b011:         w_digit = POS2;
            3'b100:         w_digit = NEG2;
            3'b101, 3'b110: w_digit = NEG1;
            default:        w_digit = ZERO;
        endcase
    end

    assign {o_neg, o_one, o_two} = w_digit;
endmodule

// File: rtl/booth_r4_mac.sv
// Sequential radix-4 Booth multiply-accumulate with valid/ready on both sides.
module booth_r4_mac
    import booth_pkg::*;
#(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
)(
    input  logic          axis_clk,
    input  logic          axis_rst_n,
    input  logic          clr,
    booth_r4_mac_if.slave bus
);
    localparam int ITER      = booth_iter(DIN1_WIDTH);
    localparam int CNT_WIDTH = $clog2(ITER + 1);
    localparam int PROD_W    = DIN0_WIDTH + DIN1_WIDTH;
    localparam int PW        = PROD_W + 4;
    localparam int YXW       = DIN1_WIDTH + 2;
    localparam int YW        = YXW + 1;

    booth_state_e         r_state;
    booth_state_e         w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [PW-1:0]        r_m;
    logic [PW-1:0]        r_psum;
    logic [YW-1:0]        r_y;
    logic                 r_sgn;
    logic                 r_acc_en;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_dout;
    logic                 r_out_valid;
    logic                 r_busy;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_neg;
    logic                 w_one;
    logic                 w_two;
    logic [PW-1:0]        w_m_ext;
    logic [YW-1:0]        w_y_ext;
    logic [PW-1:0]        w_sel;
    logic [PW-1:0]        w_digit;
    logic [PW-1:0]        w_psum_nxt;
    logic [ACC_WIDTH-1:0] w_prod_ext;
    logic [ACC_WIDTH-1:0] w_acc_nxt;

    booth_r4_enc u_enc (
        .i_triplet (r_y[2:0]),
        .o_neg     (w_neg),
        .o_one     (w_one),
        .o_two     (w_two)
    );

    // State register.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clr overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = w_accept ? CAL : IDLE;
                CAL:     w_state_nxt = w_last ? DONE : CAL;
                DONE: begin
                    if (bus.out_ready) begin
                        w_state_nxt = w_accept ? CAL : IDLE;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Handshake decode: a finished result may hand over and accept on the same edge.
    always_comb begin
        w_in_ready = 1'b0;
        if (clr) begin
            w_in_ready = 1'b0;
        end else begin
            w_in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
        end
        w_accept = bus.in_valid & w_in_ready;
        w_last   = (r_state == CAL) && (r_cnt == CNT_WIDTH'(ITER - 1));
    end

    // Two guard bits make full-range unsigned operands behave as positive numbers.
    always_comb begin
        w_m_ext = {PW{1'b0}};
        w_y_ext = {YW{1'b0}};
        if (bus.in_signed) begin
            w_m_ext = PW'($signed(bus.din0));
            w_y_ext = {YXW'($signed(bus.din1)), 1'b0};
        end else begin
            w_m_ext = PW'(bus.din0);
            w_y_ext = {YXW'(bus.din1), 1'b0};
        end
    end

    // Digit selection; r_m already carries the 4^i weight.
    always_comb begin
        w_sel = {PW{1'b0}};
        if (w_one) begin
            w_sel = r_m;
        end else if (w_two) begin
            w_sel = r_m << 1'b1;
        end else begin
            w_sel = {PW{1'b0}};
        end
        if (w_neg) begin
            w_digit = ~w_sel + PW'(1'b1);
        end else begin
            w_digit = w_sel;
        end
        w_psum_nxt = r_psum + w_digit;
    end

    // Product widening per latched mode; accumulation wraps silently.
    always_comb begin
        w_prod_ext = {ACC_WIDTH{1'b0}};
        if (r_sgn) begin
            w_prod_ext = ACC_WIDTH'($signed(w_psum_nxt[PROD_W-1:0]));
        end else begin
            w_prod_ext = ACC_WIDTH'(w_psum_nxt[PROD_W-1:0]);
        end
        if (r_acc_en) begin
            w_acc_nxt = r_acc + w_prod_ext;
        end else begin
            w_acc_nxt = w_prod_ext;
        end
    end

    // Datapath, accumulator and registered outputs.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_cnt       <= {CNT_WIDTH{1'b0}};
            r_m         <= {PW{1'b0}};
            r_psum      <= {PW{1'b0}};
            r_y         <= {YW{1'b0}};
            r_sgn       <= 1'b0;
            r_acc_en    <= 1'b0;
            r_acc       <= {ACC_WIDTH{1'b0}};
            r_dout      <= {ACC_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (clr) begin
            r_cnt       <= {CNT_WIDTH{1'b0}};
            r_acc       <= {ACC_WIDTH{1'b0}};
            r_dout      <= {ACC_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == CAL);
            if (w_accept) begin
                r_m      <= w_m_ext;
                r_y      <= w_y_ext;
                r_sgn    <= bus.in_signed;
                r_acc_en <= bus.in_acc;
                r_psum   <= {PW{1'b0}};
                r_cnt    <= {CNT_WIDTH{1'b0}};
            end else if (r_state == CAL) begin
                r_psum <= w_psum_nxt;
                r_m    <= r_m << 2'd2;
                r_y    <= r_y >> 2'd2;
                r_cnt  <= r_cnt + CNT_WIDTH'(1'b1);
            end
            if (w_last) begin
                r_acc       <= w_acc_nxt;
                r_dout      <= w_acc_nxt;
                r_out_valid <= 1'b1;
            end else if ((r_state == DONE) && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_booth_r4_mac.sv
// Directed self-checking bench for booth_r4_mac with hand-computed expected results.
module tb_booth_r4_mac;
    logic axis_clk = 1'b0;
    logic axis_rst_n;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    booth_r4_mac_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(16), .ACC_WIDTH(40)) bus ();

    booth_r4_mac #(.DIN0_WIDTH(16), .DIN1_WIDTH(16), .ACC_WIDTH(40)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .clr        (clr),
        .bus        (bus)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation: accept, latency, result, optional stall, handshake.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sgn, input logic acc, input logic [39:0] exp, input int stall);
        int n;
        @(negedge axis_clk);
        bus.din0 = a; bus.din1 = b; bus.in_signed = sgn; bus.in_acc = acc;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        #1 chk({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge axis_clk);
        @(negedge axis_clk);
        bus.in_valid = 1'b0;
        bus.din0 = ~a; bus.din1 = 16'h1234; bus.in_acc = ~acc; bus.in_signed = ~sgn;
        chk({tag, "/busy"}, 64'(bus.busy), 64'd1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge axis_clk);
            n++;
        end
        chk({tag, "/latency"}, 64'(n), 64'd9);
        chk({tag, "/dout"}, 64'(bus.dout), 64'(exp));
        chk({tag, "/busy_done"}, 64'(bus.busy), 64'd0);
        bus.in_valid = (stall > 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge axis_clk);
            chk({tag, "/stall_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "/stall_dout"}, 64'(bus.dout), 64'(exp));
            chk({tag, "/stall_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge axis_clk);
        bus.out_ready = 1'b0;
        chk({tag, "/valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "/dout_hold"}, 64'(bus.dout), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] exp;
        logic [39:0] b2b_exp [4];
        int          n;
        int          seen;

        axis_rst_n = 1'b0; clr = 1'b0;
        bus.in_valid = 1'b0; bus.din0 = 16'h0; bus.din1 = 16'h0;
        bus.in_signed = 1'b0; bus.in_acc = 1'b0; bus.out_ready = 1'b0;
        #12;
        chk("rst/dout", 64'(bus.dout), 64'd0);
        chk("rst/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst/busy", 64'(bus.busy), 64'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        #1 chk("rst/in_ready", 64'(bus.in_ready), 64'd1);

        do_op("u3x5", 16'd3, 16'd5, 1'b0, 1'b0, 40'h00_0000_000F, 0);
        do_op("s-3x5", 16'hFFFD, 16'd5, 1'b1, 1'b0, 40'hFF_FFFF_FFF1, 0);
        do_op("s8000sq", 16'h8000, 16'h8000, 1'b1, 1'b0, 40'h00_4000_0000, 0);
        do_op("uFFFFsq", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'h00_FFFE_0001, 0);

        exp = 40'h00_FFFE_0001;
        for (int k = 0; k < 256; k++) begin
            exp = exp + 40'h00_FFFE_0001;
            do_op("uacc", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, exp, 0);
        end
        chk("wrap/final", 64'(bus.dout), 64'h00_FDFE_0101);

        do_op("chain2x3", 16'd2, 16'd3, 1'b0, 1'b0, 40'd6, 0);
        do_op("chain4x5", 16'd4, 16'd5, 1'b0, 1'b1, 40'd26, 5);
        do_op("chain-1x7", 16'hFFFF, 16'd7, 1'b1, 1'b1, 40'd19, 0);

        b2b_exp[0] = 40'd1; b2b_exp[1] = 40'd5; b2b_exp[2] = 40'd14; b2b_exp[3] = 40'd30;
        @(negedge axis_clk);
        bus.din0 = 16'd1; bus.din1 = 16'd1; bus.in_signed = 1'b0; bus.in_acc = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge axis_clk);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge axis_clk);
                n++;
            end while (!bus.out_valid && n < 30);
            chk("b2b/period", 64'(n), 64'd10);
            chk("b2b/dout", 64'(bus.dout), 64'(b2b_exp[k]));
            if (k < 3) begin
                bus.din0 = 16'(k + 2); bus.din1 = 16'(k + 2); bus.in_acc = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        seen = 0;
        repeat (15) begin
            @(negedge axis_clk);
            if (bus.out_valid) seen++;
        end
        chk("b2b/no_dup", 64'(seen), 64'd0);
        bus.out_ready = 1'b0;

        @(negedge axis_clk);
        bus.din0 = 16'd9; bus.din1 = 16'd9; bus.in_acc = 1'b1; bus.in_valid = 1'b1;
        @(posedge axis_clk);
        @(negedge axis_clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge axis_clk);
        clr = 1'b1;
        #1 chk("clr/in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge axis_clk);
        clr = 1'b0;
        chk("clr/out_valid", 64'(bus.out_valid), 64'd0);
        chk("clr/busy", 64'(bus.busy), 64'd0);
        chk("clr/dout", 64'(bus.dout), 64'd0);
        seen = 0;
        repeat (15) begin
            @(negedge axis_clk);
            if (bus.out_valid) seen++;
        end
        chk("clr/no_result", 64'(seen), 64'd0);
        clr = 1'b1; bus.in_valid = 1'b1;
        #1 chk("clr_idle/in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge axis_clk);
        clr = 1'b0; bus.in_valid = 1'b0;
        chk("clr_idle/no_accept", 64'(bus.busy), 64'd0);
        do_op("clr_7x7", 16'd7, 16'd7, 1'b0, 1'b1, 40'd49, 0);

        @(negedge axis_clk);
        bus.din0 = 16'd5; bus.din1 = 16'd5; bus.in_acc = 1'b1; bus.in_valid = 1'b1;
        @(posedge axis_clk);
        @(negedge axis_clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge axis_clk);
        #2 axis_rst_n = 1'b0;
        #1;
        chk("arst/out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst/busy", 64'(bus.busy), 64'd0);
        chk("arst/dout", 64'(bus.dout), 64'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        #1 chk("arst/in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (15) begin
            @(negedge axis_clk);
            if (bus.out_valid) seen++;
        end
        chk("arst/no_result", 64'(seen), 64'd0);
        do_op("arst_7x7", 16'd7, 16'd7, 1'b0, 1'b1, 40'd49, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
